// File: rtl/li_expander.sv
// Expands a 32-bit load-immediate request into a MIPS LUI/ORI instruction pair.
// Define LI_SKIP_ZERO_HALF_EN to emit a single instruction when one half is zero.
module li_expander #(
   parameter logic [5:0] LUI_OPCODE = 6'b001111,
   parameter logic [5:0] ORI_OPCODE = 6'b001101,
   parameter int         CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_const,
   input  logic [4:0]       in_rt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_last,
   output logic             busy,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      IDLE,
      EMIT_LUI,
      EMIT_ORI
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] cval;
   logic [4:0]  rt;
   logic        lo_zero;
   logic        hi_zero;
   logic        in_fire;
   logic        out_fire;

   assign lo_zero  = (cval[15:0] == 16'd0);
   assign hi_zero  = (cval[31:16] == 16'd0);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cval <= 32'd0;
         rt   <= 5'd0;
      end else if (in_fire) begin
         cval <= in_const;
         rt   <= in_rt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_count <= '0;
      end else if (out_fire) begin
         instr_count <= instr_count + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
`ifdef LI_SKIP_ZERO_HALF_EN
               if (in_const[31:16] == 16'd0 && in_const[15:0] != 16'd0) begin
                  state_nxt = EMIT_ORI;
               end else begin
                  state_nxt = EMIT_LUI;
               end
`else
               state_nxt = EMIT_LUI;
`endif
            end
         end
         EMIT_LUI: begin
            if (out_ready) begin
`ifdef LI_SKIP_ZERO_HALF_EN
               state_nxt = lo_zero ? IDLE : EMIT_ORI;
`else
               state_nxt = EMIT_ORI;
`endif
            end
         end
         EMIT_ORI: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs depend only on state and latched request, never on in_*.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state != IDLE);
      busy      = (state != IDLE);
      out_instr = 32'd0;
      out_last  = 1'b0;
      unique case (state)
         EMIT_LUI: begin
            out_instr = {LUI_OPCODE, 5'd0, rt, cval[31:16]};
`ifdef LI_SKIP_ZERO_HALF_EN
            out_last  = lo_zero;
`else
            out_last  = 1'b0;
`endif
         end
         EMIT_ORI: begin
`ifdef LI_SKIP_ZERO_HALF_EN
            out_instr = {ORI_OPCODE, (hi_zero ? 5'd0 : rt), rt, cval[15:0]};
`else
            out_instr = {ORI_OPCODE, rt, rt, cval[15:0]};
`endif
            out_last  = 1'b1;
         end
         default: begin
            out_instr = 32'd0;
            out_last  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_li_expander.sv
// Self-checking bench for li_expander against a word-list reference model.
// Honors LI_SKIP_ZERO_HALF_EN in the model when defined.
module tb_li_expander;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_const;
   logic [4:0]    in_rt;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic          out_last;
   logic          busy;
   logic [CW-1:0] instr_count;

   int            pass_cnt  = 0;
   int            total_cnt = 0;
   logic [CW-1:0] exp_count;

   li_expander #(.CNT_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_const    (in_const),
      .in_rt       (in_rt),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_last    (out_last),
      .busy        (busy),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   // Expected instruction words for one request, built from the field layout.
   task automatic model(input logic [31:0] c, input logic [4:0] r,
                        output logic [31:0] w0, output logic [31:0] w1,
                        output int n);
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] lui;
      logic [31:0] ori;
      hi  = c >> 16;
      lo  = c & 32'h0000_FFFF;
      lui = (32'd15 << 26) | (32'(r) << 16) | hi;
      ori = (32'd13 << 26) | (32'(r) << 21) | (32'(r) << 16) | lo;
      w0  = lui;
      w1  = ori;
      n   = 2;
`ifdef LI_SKIP_ZERO_HALF_EN
      if (lo == 0) begin
         n = 1;
      end else if (hi == 0) begin
         w0 = (32'd13 << 26) | (32'(r) << 16) | lo;
         n  = 1;
      end
`endif
   endtask

   task automatic check_idle(input string tag, input logic [CW-1:0] cnt);
      total_cnt++;
      if ({out_valid, out_last, in_ready, busy, out_instr, instr_count} !==
          {1'b0, 1'b0, 1'b1, 1'b0, 32'h0, cnt}) begin
         $display("FAIL %s: got v=%b l=%b ir=%b b=%b i=%h c=%0d want idle c=%0d",
                  tag, out_valid, out_last, in_ready, busy, out_instr,
                  instr_count, cnt);
      end else begin
         pass_cnt++;
      end
   endtask

   // Drive one request and follow every output cycle until it completes.
   task automatic send(input logic [31:0] c, input logic [4:0] r,
                       input int lui_stall, input bit rnd, input bit hold);
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w;
      logic        lst;
      int          n;
      int          i;
      int          stall;
      int          guard;
      model(c, r, w0, w1, n);
      in_valid  = 1'b1;
      in_const  = c;
      in_rt     = r;
      out_ready = 1'b0;
      @(negedge clk);
      if (hold) begin
         in_const = ~c;
         in_rt    = r + 5'd1;
      end else begin
         in_valid = 1'b0;
      end
      i = 0;
      stall = 0;
      guard = 0;
      while (i < n && guard < 100) begin
         w   = (i == 0) ? w0 : w1;
         lst = (i == n - 1);
         total_cnt++;
         if ({out_valid, out_last, in_ready, busy, out_instr, instr_count} !==
             {1'b1, lst, 1'b0, 1'b1, w, exp_count}) begin
            $display("FAIL word%0d c=%h: got v=%b l=%b ir=%b b=%b i=%h cnt=%0d want l=%b i=%h cnt=%0d",
                     i, c, out_valid, out_last, in_ready, busy, out_instr,
                     instr_count, lst, w, exp_count);
         end else begin
            pass_cnt++;
         end
         if (i == 0 && stall < lui_stall) out_ready = 1'b0;
         else if (rnd && stall < 5) out_ready = 1'($urandom_range(0, 1));
         else out_ready = 1'b1;
         if (out_ready) begin
            exp_count++;
            i++;
            stall = 0;
            if (i == n) in_valid = 1'b0;
         end else begin
            stall++;
         end
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         total_cnt++;
         $display("FAIL timeout c=%h: words done=%0d want %0d", c, i, n);
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_idle("after_req", exp_count);
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_const  = 32'h0;
      in_rt     = 5'd0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      exp_count = '0;
      check_idle("reset_hold", exp_count);
      reset = 1'b0;
      @(negedge clk);
      check_idle("reset_release", exp_count);
   endtask

   task automatic test_basic();
      send(32'h1234_5678, 5'd8, 0, 1'b0, 1'b0);
      send(32'h0000_0000, 5'd3, 0, 1'b0, 1'b0);
      send(32'h0000_ABCD, 5'd5, 0, 1'b0, 1'b0);
      send(32'hFFFF_0000, 5'd5, 0, 1'b0, 1'b0);
      send(32'hDEAD_BEEF, 5'd0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_stall();
      send(32'h1234_5678, 5'd8, 4, 1'b0, 1'b0);
      send(32'hCAFE_0001, 5'd31, 7, 1'b1, 1'b0);
   endtask

   task automatic test_busy_ignore();
      send(32'h8765_4321, 5'd12, 2, 1'b0, 1'b1);
      send(32'h0F0F_F0F0, 5'd1, 0, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [31:0] w0;
      logic [31:0] w1;
      int          n;
      model(32'h1234_5678, 5'd9, w0, w1, n);
      in_valid  = 1'b1;
      in_const  = 32'h1234_5678;
      in_rt     = 5'd9;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({out_valid, out_last, out_instr} !== {1'b1, 1'b1, w1}) begin
         $display("FAIL mid_ori: got v=%b l=%b i=%h want v=1 l=1 i=%h",
                  out_valid, out_last, out_instr, w1);
      end else begin
         pass_cnt++;
      end
      reset = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      out_ready = 1'b0;
      exp_count = '0;
      check_idle("mid_reset", exp_count);
      send(32'hA5A5_5A5A, 5'd17, 0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] c;
      for (int k = 0; k < 40; k++) begin
         c = $urandom;
         case ($urandom_range(0, 3))
            0: c[15:0] = 16'h0;
            1: c[31:16] = 16'h0;
            default: ;
         endcase
         send(c, 5'($urandom_range(0, 31)), 0, 1'b1, 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_wrap();
      logic [CW-1:0] start;
      start = exp_count;
      for (int k = 0; k < 8; k++) begin
         send(32'h1111_2222 + k, 5'(k), 0, 1'b0, 1'b0);
      end
      total_cnt++;
      if (instr_count !== start) begin
         $display("FAIL wrap: got %0d want %0d", instr_count, start);
      end else begin
         pass_cnt++;
      end
   endtask

   initial begin
      exp_count = '0;
      test_reset();
      test_basic();
      test_stall();
      test_busy_ignore();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
